// File: rtl/mxu_pkg.sv
// Shared definitions for the systolic matmul tile sequencer.
// Opcode constants, instruction field positions, the sequencer state
// encoding and the default tile dimensions.
package mxu_pkg;

    // Default tile geometry
    localparam int MXU_SIZE       = 4;
    localparam int MXU_DATA_WIDTH = 8;
    localparam int MXU_IDX_W      = 2;

    // Opcodes in instruction[15:14]
    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_LOAD    = 2'b01;
    localparam logic [1:0] OP_COMPUTE = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    // Instruction field bit positions (low bit of each field)
    localparam int F_OP_LO   = 14;
    localparam int F_TARGET  = 13;
    localparam int F_LINE_LO = 11;
    localparam int F_ELEM_LO = 9;
    localparam int F_ROW_LO  = 11;
    localparam int F_COL_LO  = 9;
    localparam int F_DATA_LO = 0;

    // Compute sequence states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_FEED  = 2'b10,
        ST_DRAIN = 2'b11
    } seq_state_e;

    // True for opcodes that are refused while a sequence is running
    function automatic logic op_is_exclusive(input logic [1:0] op);
        return (op == OP_LOAD) || (op == OP_COMPUTE);
    endfunction

endpackage

// File: rtl/mxu_instr_decode.sv
// Instruction field extraction and COMPUTE start detection.
// Purely combinational; the previous opcode and busy state are supplied
// by the sequencer, which owns all registers.
module mxu_instr_decode
    import mxu_pkg::*;
#(
    parameter int DATA_WIDTH = MXU_DATA_WIDTH,
    parameter int IDX_W      = MXU_IDX_W
) (
    input  logic [15:0]           instruction,
    input  logic [1:0]            prev_opcode,
    input  logic                  busy,
    output logic [1:0]            opcode,
    output logic                  load_a,
    output logic                  load_b,
    output logic                  compute_start,
    output logic                  read_sel,
    output logic                  drop,
    output logic [IDX_W-1:0]      line,
    output logic [IDX_W-1:0]      elem,
    output logic [IDX_W-1:0]      row,
    output logic [IDX_W-1:0]      col,
    output logic [DATA_WIDTH-1:0] data
);

    // Bit 8 carries no meaning in any opcode
    logic unused_bit_s;

    assign opcode       = instruction[F_OP_LO +: 2];
    assign line         = instruction[F_LINE_LO +: IDX_W];
    assign elem         = instruction[F_ELEM_LO +: IDX_W];
    assign row          = instruction[F_ROW_LO +: IDX_W];
    assign col          = instruction[F_COL_LO +: IDX_W];
    assign data         = instruction[F_DATA_LO +: DATA_WIDTH];
    assign unused_bit_s = instruction[8];

    // Classify the opcode; LOAD/COMPUTE while busy become a drop request
    always_comb begin
        load_a        = 1'b0;
        load_b        = 1'b0;
        compute_start = 1'b0;
        read_sel      = 1'b0;
        drop          = 1'b0;
        case (opcode)
            OP_LOAD: begin
                if (busy) begin
                    drop = 1'b1;
                end else begin
                    load_a = ~instruction[F_TARGET];
                    load_b = instruction[F_TARGET];
                end
            end
            OP_COMPUTE: begin
                if (busy) begin
                    drop = 1'b1;
                end else begin
                    // Only a rising COMPUTE starts a sequence
                    compute_start = (prev_opcode != OP_COMPUTE);
                end
            end
            OP_READ: begin
                read_sel = 1'b1;
            end
            default: begin
                read_sel = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mxu_sequencer.sv
// Instruction decoder and compute sequencer for the 4x4 systolic tile.
// Decodes LOAD/READ/COMPUTE, issues operand memory write strobes and
// runs the CLEAR -> FEED -> DRAIN compute sequence. All outputs are
// registered.
// Build option: define SEQ_PERF_EN to enable the completed-COMPUTE
// counter on perf_count; otherwise perf_count is tied to zero.
module mxu_sequencer
    import mxu_pkg::*;
#(
    parameter int SIZE       = MXU_SIZE,
    parameter int DATA_WIDTH = MXU_DATA_WIDTH,
    parameter int IDX_W      = MXU_IDX_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           instruction,
    output logic                  array_write_enable,
    output logic                  array_clear,
    output logic [IDX_W-1:0]      array_output_row,
    output logic [IDX_W-1:0]      array_output_col,
    output logic [DATA_WIDTH-1:0] mema_data_in,
    output logic [DATA_WIDTH-1:0] memb_data_in,
    output logic                  mema_write_enable,
    output logic                  memb_write_enable,
    output logic [IDX_W-1:0]      mema_write_line,
    output logic [IDX_W-1:0]      memb_write_line,
    output logic [IDX_W-1:0]      mema_write_elem,
    output logic [IDX_W-1:0]      memb_write_elem,
    output logic                  mema_read_enable,
    output logic                  memb_read_enable,
    output logic [IDX_W-1:0]      mema_read_elem,
    output logic [IDX_W-1:0]      memb_read_elem,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           perf_count
);

    localparam int STEP_W = $clog2(3 * SIZE);
    // Step runs 0..SIZE-1 in FEED then continues to 3*SIZE-3 in DRAIN
    localparam logic [STEP_W-1:0] FEED_LAST  = STEP_W'(SIZE - 1);
    localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'(3 * SIZE - 3);

    // Decoder outputs
    logic [1:0]            opcode_s;
    logic                  load_a_s;
    logic                  load_b_s;
    logic                  start_s;
    logic                  read_sel_s;
    logic                  drop_s;
    logic [IDX_W-1:0]      line_s;
    logic [IDX_W-1:0]      elem_s;
    logic [IDX_W-1:0]      row_s;
    logic [IDX_W-1:0]      col_s;
    logic [DATA_WIDTH-1:0] data_s;

    // State and output registers
    seq_state_e            state_r;
    logic [STEP_W-1:0]     step_r;
    logic [1:0]            prev_op_r;
    logic                  clear_r;
    logic                  awe_r;
    logic                  rd_en_r;
    logic [IDX_W-1:0]      rd_elem_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  err_r;
    logic [IDX_W-1:0]      row_r;
    logic [IDX_W-1:0]      col_r;
    logic                  wea_r;
    logic                  web_r;
    logic [IDX_W-1:0]      line_a_r;
    logic [IDX_W-1:0]      line_b_r;
    logic [IDX_W-1:0]      elem_a_r;
    logic [IDX_W-1:0]      elem_b_r;
    logic [DATA_WIDTH-1:0] data_a_r;
    logic [DATA_WIDTH-1:0] data_b_r;
    logic                  seq_last_s;

    mxu_instr_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_decode (
        .instruction   (instruction),
        .prev_opcode   (prev_op_r),
        .busy          (busy_r),
        .opcode        (opcode_s),
        .load_a        (load_a_s),
        .load_b        (load_b_s),
        .compute_start (start_s),
        .read_sel      (read_sel_s),
        .drop          (drop_s),
        .line          (line_s),
        .elem          (elem_s),
        .row           (row_s),
        .col           (col_s),
        .data          (data_s)
    );

    // Final DRAIN cycle: sequence completes at the next edge
    assign seq_last_s = (state_r == ST_DRAIN) && (step_r == DRAIN_LAST);

    // Remember the last sampled opcode for COMPUTE edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_op_r <= OP_NOP;
        end else begin
            prev_op_r <= opcode_s;
        end
    end

    // Compute sequence FSM with its step counter and timed outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            step_r    <= '0;
            clear_r   <= 1'b0;
            awe_r     <= 1'b0;
            rd_en_r   <= 1'b0;
            rd_elem_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            clear_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    step_r    <= '0;
                    awe_r     <= 1'b0;
                    rd_en_r   <= 1'b0;
                    rd_elem_r <= '0;
                    if (start_s) begin
                        state_r <= ST_CLEAR;
                        clear_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    state_r   <= ST_FEED;
                    step_r    <= '0;
                    awe_r     <= 1'b1;
                    rd_en_r   <= 1'b1;
                    rd_elem_r <= '0;
                    busy_r    <= 1'b1;
                end
                ST_FEED: begin
                    step_r <= step_r + STEP_W'(1);
                    if (step_r == FEED_LAST) begin
                        state_r   <= ST_DRAIN;
                        rd_en_r   <= 1'b0;
                        rd_elem_r <= '0;
                    end else begin
                        state_r   <= ST_FEED;
                        rd_en_r   <= 1'b1;
                        rd_elem_r <= IDX_W'(step_r + STEP_W'(1));
                    end
                end
                ST_DRAIN: begin
                    if (seq_last_s) begin
                        state_r <= ST_IDLE;
                        step_r  <= '0;
                        awe_r   <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                        step_r  <= step_r + STEP_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    step_r    <= '0;
                    awe_r     <= 1'b0;
                    rd_en_r   <= 1'b0;
                    rd_elem_r <= '0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error: LOAD or COMPUTE arrived while a sequence was running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (drop_s && op_is_exclusive(opcode_s)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Memory A/B write strobes with line, element and data held alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wea_r    <= 1'b0;
            web_r    <= 1'b0;
            line_a_r <= '0;
            line_b_r <= '0;
            elem_a_r <= '0;
            elem_b_r <= '0;
            data_a_r <= '0;
            data_b_r <= '0;
        end else begin
            wea_r <= load_a_s;
            web_r <= load_b_s;
            if (load_a_s) begin
                line_a_r <= line_s;
                elem_a_r <= elem_s;
                data_a_r <= data_s;
            end else begin
                line_a_r <= line_a_r;
                elem_a_r <= elem_a_r;
                data_a_r <= data_a_r;
            end
            if (load_b_s) begin
                line_b_r <= line_s;
                elem_b_r <= elem_s;
                data_b_r <= data_s;
            end else begin
                line_b_r <= line_b_r;
                elem_b_r <= elem_b_r;
                data_b_r <= data_b_r;
            end
        end
    end

    // Result readout select, updated by READ even during a sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_r <= '0;
            col_r <= '0;
        end else if (read_sel_s) begin
            row_r <= row_s;
            col_r <= col_s;
        end else begin
            row_r <= row_r;
            col_r <= col_r;
        end
    end

`ifdef SEQ_PERF_EN
    logic [15:0] perf_r;

    // Count completed sequences; wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_r <= 16'h0000;
        end else if (seq_last_s) begin
            perf_r <= perf_r + 16'h0001;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign perf_count = perf_r;
`else
    assign perf_count = 16'h0000;
`endif

    assign array_write_enable = awe_r;
    assign array_clear        = clear_r;
    assign array_output_row   = row_r;
    assign array_output_col   = col_r;
    assign mema_data_in       = data_a_r;
    assign memb_data_in       = data_b_r;
    assign mema_write_enable  = wea_r;
    assign memb_write_enable  = web_r;
    assign mema_write_line    = line_a_r;
    assign memb_write_line    = line_b_r;
    assign mema_write_elem    = elem_a_r;
    assign memb_write_elem    = elem_b_r;
    assign mema_read_enable   = rd_en_r;
    assign memb_read_enable   = rd_en_r;
    assign mema_read_elem     = rd_elem_r;
    assign memb_read_elem     = rd_elem_r;
    assign busy               = busy_r;
    assign done               = done_r;
    assign err                = err_r;

endmodule
